// File: rtl/uart_program_loader_if.sv
// Manual write port of the 16-byte program memory, driven by the UART loader.
interface uart_program_loader_if;
  logic [3:0] manual_addr;
  logic [7:0] manual_value;
  logic       manual_WE;
  logic       PROG;

  modport master (output manual_addr, manual_value, manual_WE, PROG);
  modport slave  (input  manual_addr, manual_value, manual_WE, PROG);
endinterface

// File: rtl/uart_program_loader.sv
// Receives a framed program image (HEADER, MEM_DEPTH data bytes, checksum) over 8N1 UART
// and writes it byte by byte into program memory through the manual write port.
module uart_program_loader #(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD      = 115200,
  parameter int         MEM_DEPTH = 16,
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         WE_HOLD   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 start,
  uart_program_loader_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err,
  output logic                 cksum_err,
  output logic [4:0]           byte_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int WE_W         = $clog2(WE_HOLD + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_SYNC, L_ADDR, L_WE, L_NEXT, L_CKSUM, L_DONE} l_state_t;

  rx_state_t        rx_state, rx_next;
  l_state_t         l_state, l_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             half_tick, bit_tick, rx_valid, rx_ferr;
  logic [7:0]       sum;
  logic [3:0]       index;
  logic [WE_W-1:0]  we_cnt;
  logic             byte_pend;

  // rx_prev is the synchronized value one cycle earlier, used for start-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign half_tick = (bit_cnt == CNT_W'(HALF_BIT - 1));
  assign bit_tick  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign rx_valid  = (rx_state == RX_STOP) && bit_tick && rx_sync;
  assign rx_ferr   = (rx_state == RX_STOP) && bit_tick && !rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      rx_byte <= 8'd0;
    end else begin
      case (rx_state)
        RX_START: bit_cnt <= half_tick ? '0 : bit_cnt + 1'b1;
        RX_DATA: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            rx_byte <= {rx_sync, rx_byte[7:1]};
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_STOP: bit_cnt <= bit_tick ? '0 : bit_cnt + 1'b1;
        default: begin
          bit_cnt <= '0;
          bit_idx <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) l_state <= L_IDLE;
    else      l_state <= l_next;
  end

  // byte_pend gives address/data a full cycle of setup before the write strobe
  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE:  if (start) l_next = L_SYNC;
      L_SYNC:  if (rx_valid && rx_byte == HEADER) l_next = L_ADDR;
      L_ADDR: begin
        if (byte_pend)    l_next = L_WE;
        else if (rx_ferr) l_next = L_IDLE;
      end
      L_WE:    if (we_cnt == WE_W'(WE_HOLD - 1)) l_next = L_NEXT;
      L_NEXT:  l_next = (index == 4'(MEM_DEPTH - 1)) ? L_CKSUM : L_ADDR;
      L_CKSUM: begin
        if (rx_valid)     l_next = (rx_byte == sum) ? L_DONE : L_IDLE;
        else if (rx_ferr) l_next = L_IDLE;
      end
      L_DONE:  l_next = L_IDLE;
      default: l_next = L_IDLE;
    endcase
  end

  assign busy          = (l_state == L_SYNC) || (l_state == L_ADDR) || (l_state == L_WE) ||
                         (l_state == L_NEXT) || (l_state == L_CKSUM);
  assign mem.PROG      = busy;
  assign mem.manual_WE = (l_state == L_WE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.manual_addr  <= 4'd0;
      mem.manual_value <= 8'd0;
      done             <= 1'b0;
      frame_err        <= 1'b0;
      cksum_err        <= 1'b0;
      byte_count       <= 5'd0;
      sum              <= 8'd0;
      index            <= 4'd0;
      we_cnt           <= '0;
      byte_pend        <= 1'b0;
    end else begin
      byte_pend <= 1'b0;
      we_cnt    <= '0;
      case (l_state)
        L_IDLE: begin
          if (start) begin
            done       <= 1'b0;
            frame_err  <= 1'b0;
            cksum_err  <= 1'b0;
            byte_count <= 5'd0;
            sum        <= 8'd0;
          end
        end
        L_SYNC: if (rx_valid && rx_byte == HEADER) index <= 4'd0;
        L_ADDR: begin
          if (rx_valid && !byte_pend) begin
            mem.manual_value <= rx_byte;
            mem.manual_addr  <= index;
            sum              <= sum + rx_byte;
            byte_pend        <= 1'b1;
          end else if (rx_ferr && !byte_pend) begin
            frame_err <= 1'b1;
          end
        end
        L_WE: we_cnt <= we_cnt + 1'b1;
        L_NEXT: begin
          byte_count <= byte_count + 5'd1;
          if (index != 4'(MEM_DEPTH - 1)) index <= index + 4'd1;
        end
        L_CKSUM: begin
          if (rx_valid) begin
            if (rx_byte == sum) done      <= 1'b1;
            else                cksum_err <= 1'b1;
          end else if (rx_ferr) begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader at 16 clocks per bit: table-driven image loads plus glitch and reset cases.
module tb_uart_program_loader;

  localparam int         CPB    = 16;
  localparam int         HOLD   = 4;
  localparam logic [7:0] HDR    = 8'hA5;
  localparam int         OBS_SZ = 128;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] val;
  } wr_t;

  typedef struct {
    bit         junk;
    logic [7:0] cksum;
    int         ferr_idx;
    bit         exp_done;
    bit         exp_cerr;
    bit         exp_ferr;
    logic [4:0] exp_count;
  } vec_t;

  logic clk, rst, rx, start;
  logic busy, done, frame_err, cksum_err;
  logic [4:0] byte_count;

  uart_program_loader_if bus();

  uart_program_loader #(
    .CLK_FREQ (16),
    .BAUD     (1),
    .MEM_DEPTH(16),
    .HEADER   (HDR),
    .WE_HOLD  (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .start     (start),
    .mem       (bus),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .cksum_err (cksum_err),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: records every manual_WE pulse with its address, data and width
  logic       we_prev = 1'b0;
  int         wid = 0;
  logic [3:0] cur_addr = 4'd0;
  logic [7:0] cur_val = 8'd0;
  int         obs_n = 0;
  logic [3:0] obs_addr [OBS_SZ];
  logic [7:0] obs_val  [OBS_SZ];
  int         obs_wid  [OBS_SZ];

  always @(negedge clk) begin
    if (bus.manual_WE && !we_prev) begin
      wid      <= 1;
      cur_addr <= bus.manual_addr;
      cur_val  <= bus.manual_value;
    end else if (bus.manual_WE) begin
      wid <= wid + 1;
    end else if (we_prev && obs_n < OBS_SZ) begin
      obs_addr[obs_n] <= cur_addr;
      obs_val[obs_n]  <= cur_val;
      obs_wid[obs_n]  <= wid;
      obs_n           <= obs_n + 1;
    end
    we_prev <= bus.manual_WE;
  end

  int   checks = 0;
  int   passed = 0;
  int   rd_ptr = 0;
  wr_t  exp_q[$];
  vec_t vecs[4];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bit aborted;
    aborted = 1'b0;
    pulse_start();
    check_output("busy after start", {31'd0, busy}, 32'd1);
    if (v.junk) begin
      send_byte(8'h3C, 1'b1);
      send_byte(8'hFF, 1'b1);
      check_output("no write before header", obs_n - rd_ptr, 32'd0);
    end
    send_byte(HDR, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k == v.ferr_idx) aborted = 1'b1;
      else if (!aborted) exp_q.push_back({4'(k), 8'(k)});
      send_byte(8'(k), k != v.ferr_idx);
    end
    send_byte(v.cksum, 1'b1);
    repeat (48) @(negedge clk);
  endtask

  task automatic check_writes(input int tag);
    wr_t e;
    check_output($sformatf("vec%0d write count", tag), obs_n - rd_ptr, exp_q.size());
    while (exp_q.size() > 0 && rd_ptr < obs_n) begin
      e = exp_q.pop_front();
      check_output($sformatf("vec%0d addr", tag), {28'd0, obs_addr[rd_ptr]}, {28'd0, e.addr});
      check_output($sformatf("vec%0d value", tag), {24'd0, obs_val[rd_ptr]}, {24'd0, e.val});
      check_output($sformatf("vec%0d WE width", tag), obs_wid[rd_ptr], HOLD);
      rd_ptr++;
    end
    exp_q.delete();
    rd_ptr = obs_n;
  endtask

  task automatic check_vector(input int tag, input vec_t v);
    check_writes(tag);
    check_output($sformatf("vec%0d done", tag), {31'd0, done}, {31'd0, v.exp_done});
    check_output($sformatf("vec%0d cksum_err", tag), {31'd0, cksum_err}, {31'd0, v.exp_cerr});
    check_output($sformatf("vec%0d frame_err", tag), {31'd0, frame_err}, {31'd0, v.exp_ferr});
    check_output($sformatf("vec%0d byte_count", tag), {27'd0, byte_count}, {27'd0, v.exp_count});
    check_output($sformatf("vec%0d PROG", tag), {31'd0, bus.PROG}, 32'd0);
    check_output($sformatf("vec%0d busy", tag), {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string when);
    check_output({when, " manual_addr"}, {28'd0, bus.manual_addr}, 32'd0);
    check_output({when, " manual_value"}, {24'd0, bus.manual_value}, 32'd0);
    check_output({when, " manual_WE"}, {31'd0, bus.manual_WE}, 32'd0);
    check_output({when, " PROG"}, {31'd0, bus.PROG}, 32'd0);
    check_output({when, " busy"}, {31'd0, busy}, 32'd0);
    check_output({when, " done"}, {31'd0, done}, 32'd0);
    check_output({when, " frame_err"}, {31'd0, frame_err}, 32'd0);
    check_output({when, " cksum_err"}, {31'd0, cksum_err}, 32'd0);
    check_output({when, " byte_count"}, {27'd0, byte_count}, 32'd0);
  endtask

  initial begin
    int  base;
    bit  hit;
    vec_t g;

    vecs[0] = '{junk: 1'b0, cksum: 8'h78, ferr_idx: -1, exp_done: 1'b1, exp_cerr: 1'b0, exp_ferr: 1'b0, exp_count: 5'd16};
    vecs[1] = '{junk: 1'b1, cksum: 8'h78, ferr_idx: -1, exp_done: 1'b1, exp_cerr: 1'b0, exp_ferr: 1'b0, exp_count: 5'd16};
    vecs[2] = '{junk: 1'b0, cksum: 8'h00, ferr_idx: -1, exp_done: 1'b0, exp_cerr: 1'b1, exp_ferr: 1'b0, exp_count: 5'd16};
    vecs[3] = '{junk: 1'b0, cksum: 8'h78, ferr_idx: 3,  exp_done: 1'b0, exp_cerr: 1'b0, exp_ferr: 1'b1, exp_count: 5'd3};

    rst = 1'b0;
    rx = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i]);
      check_vector(i, vecs[i]);
    end

    // A short low pulse on idle rx must not be taken as a byte while waiting for data
    pulse_start();
    send_byte(HDR, 1'b1);
    base = obs_n;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_output("glitch no write", obs_n - base, 32'd0);
    check_output("glitch byte_count", {27'd0, byte_count}, 32'd0);
    check_output("glitch PROG", {31'd0, bus.PROG}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({4'(k), 8'(k)});
      send_byte(8'(k), 1'b1);
    end
    send_byte(8'h78, 1'b1);
    repeat (48) @(negedge clk);
    g = vecs[0];
    check_vector(4, g);

    // Reset in the middle of the second write strobe
    pulse_start();
    send_byte(HDR, 1'b1);
    base = obs_n;
    hit = 1'b0;
    send_byte(8'h00, 1'b1);
    fork
      send_byte(8'h01, 1'b1);
      begin
        for (int i = 0; i < 400 && !hit; i++) begin
          @(negedge clk);
          if (obs_n == base + 1 && bus.manual_WE) begin
            hit = 1'b1;
            rst = 1'b0;
            #1;
            check_output("reset WE same cycle", {31'd0, bus.manual_WE}, 32'd0);
            check_output("reset PROG same cycle", {31'd0, bus.PROG}, 32'd0);
            check_output("reset busy same cycle", {31'd0, busy}, 32'd0);
          end
        end
      end
    join
    check_output("2nd WE seen", {31'd0, hit}, 32'd1);
    check_all_zero("mid-image reset");
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
